// File: rtl/sr_cmd_decoder.sv
// Set/reset command-pair decoder: tracks per-bit SR register state and unknown bits,
// recovers D, and counts forbidden S=R=1 transfers. Results go out via a one-entry buffer.
module sr_cmd_decoder #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     s,
  input  logic [WIDTH-1:0]     r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qb,
  output logic [WIDTH-1:0]     unk,
  output logic [WIDTH-1:0]     d_rec,
  output logic [WIDTH-1:0]     d_mask,
  output logic [WIDTH-1:0]     illegal,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]           state_r, state_nxt_s;
  logic                 accept_s;
  logic [WIDTH-1:0]     q_r, unk_r, qb_r, d_rec_r, d_mask_r, illegal_r;
  logic [WIDTH-1:0]     q_nxt_s, unk_nxt_s;
  logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_nxt_s;
  logic                 err_sticky_r, err_sticky_nxt_s;
  logic                 illegal_any_s;

  assign in_ready      = (state_r == ST_EMPTY) || out_ready;
  assign accept_s      = in_valid && in_ready;
  assign illegal_any_s = |(s & r);

  // Buffer occupancy: a full buffer drained in the same cycle may be refilled.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: state_nxt_s = accept_s ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (out_ready) begin
          state_nxt_s = accept_s ? ST_FULL : ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Per-bit SR next state; 11 forces q low and marks the bit unknown.
  always_comb begin
    q_nxt_s   = q_r;
    unk_nxt_s = unk_r;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s[i], r[i]})
        2'b01: begin
          q_nxt_s[i]   = 1'b0;
          unk_nxt_s[i] = 1'b0;
        end
        2'b10: begin
          q_nxt_s[i]   = 1'b1;
          unk_nxt_s[i] = 1'b0;
        end
        2'b11: begin
          q_nxt_s[i]   = 1'b0;
          unk_nxt_s[i] = 1'b1;
        end
        default: begin
          q_nxt_s[i]   = q_r[i];
          unk_nxt_s[i] = unk_r[i];
        end
      endcase
    end
  end

  // Error counter: a new illegal event on the clearing edge still counts as one.
  always_comb begin
    err_cnt_nxt_s    = err_cnt_r;
    err_sticky_nxt_s = err_sticky_r;
    if (accept_s && illegal_any_s) begin
      err_sticky_nxt_s = 1'b1;
      if (clr_err) begin
        err_cnt_nxt_s = CNT_ONE;
      end else if (err_cnt_r != CNT_MAX) begin
        err_cnt_nxt_s = err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_nxt_s = err_cnt_r;
      end
    end else if (clr_err) begin
      err_cnt_nxt_s    = {ERR_CNT_W{1'b0}};
      err_sticky_nxt_s = 1'b0;
    end else begin
      err_cnt_nxt_s    = err_cnt_r;
      err_sticky_nxt_s = err_sticky_r;
    end
  end

  // Buffer state and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      err_cnt_r    <= {ERR_CNT_W{1'b0}};
      err_sticky_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      err_cnt_r    <= err_cnt_nxt_s;
      err_sticky_r <= err_sticky_nxt_s;
    end
  end

  // SR state and result fields, loaded only on accept so a stalled buffer stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= {WIDTH{1'b0}};
      unk_r     <= {WIDTH{1'b0}};
      qb_r      <= {WIDTH{1'b1}};
      d_rec_r   <= {WIDTH{1'b0}};
      d_mask_r  <= {WIDTH{1'b0}};
      illegal_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      q_r       <= q_nxt_s;
      unk_r     <= unk_nxt_s;
      qb_r      <= ~q_nxt_s & ~unk_nxt_s;
      d_rec_r   <= s & (s ^ r);
      d_mask_r  <= s ^ r;
      illegal_r <= s & r;
    end
  end

  assign out_valid  = (state_r == ST_FULL);
  assign q          = q_r;
  assign qb         = qb_r;
  assign unk        = unk_r;
  assign d_rec      = d_rec_r;
  assign d_mask     = d_mask_r;
  assign illegal    = illegal_r;
  assign err_cnt    = err_cnt_r;
  assign err_sticky = err_sticky_r;

endmodule
